pl_word_buffer: RTL and testbench

- Downstream stage of the serial-receive controller. Captures each 6-bit parallel word the controller presents on its PL_OUT/valid outputs and stores it in a small circular FIFO.
- Presents stored words to a consumer over a read-enable handshake.
- Decouples the bursty serial-receive rate from the consumer. Reports fill level and a sticky overflow flag.

---
 rtl/pl_word_buffer_if.sv | 37 +++
 rtl/pl_word_buffer.sv | 93 +++++++++
 tb/tb_pl_word_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pl_word_buffer_if.sv
// Handshake/data bundle between the serial-receive controller, the word
// buffer and its consumer.
//   valid_in   : word-ready level from the controller
//   pl_in      : parallel word from the controller
//   rd_en      : consumer read request
//   clr_ovf    : synchronous clear of the sticky overflow flag
//   dout       : registered read data
//   dout_valid : one-cycle pulse, dout holds a freshly read word
//   full/empty : fill-state decodes of count
//   count      : number of stored words, 0..DEPTH
//   overflow   : sticky, a write was dropped while full
// master = producer/consumer side, slave = buffer side.
interface pl_word_buffer_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned AW    = 3
);
  logic             valid_in;
  logic [WIDTH-1:0] pl_in;
  logic             rd_en;
  logic             clr_ovf;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;

  modport master (
    output valid_in, pl_in, rd_en, clr_ovf,
    input  dout, dout_valid, full, empty, count, overflow
  );

  modport slave (
    input  valid_in, pl_in, rd_en, clr_ovf,
    output dout, dout_valid, full, empty, count, overflow
  );
endinterface

// File: rtl/pl_word_buffer.sv
// Circular word FIFO behind the serial-receive controller. Each rising edge
// of valid_in captures pl_in once; the consumer reads with rd_en and gets the
// word on dout one cycle later, flagged by a dout_valid pulse.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : pl_word_buffer_if.slave (valid_in, pl_in, rd_en, clr_ovf in;
//         dout, dout_valid, full, empty, count, overflow out)
module pl_word_buffer #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  pl_word_buffer_if.slave    bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             overflow_r;
  logic             valid_q;

  logic full_w;
  logic empty_w;
  logic wr_req;
  logic rd_acc;
  logic wr_acc;
  logic wr_drop;

  assign full_w  = (count_r == (AW+1)'(DEPTH));
  assign empty_w = (count_r == '0);

  // valid_in may be held for many cycles; only its rising edge writes.
  assign wr_req  = bus.valid_in & ~valid_q;
  assign rd_acc  = bus.rd_en & ~empty_w;
  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr_acc  = wr_req & (~full_w | rd_acc);
  assign wr_drop = wr_req & ~wr_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_r      <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      valid_q      <= bus.valid_in;
      dout_valid_r <= rd_acc;
      if (rd_acc) begin
        dout_r <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      // A dropped write takes priority over a same-cycle clear.
      if (wr_drop) begin
        overflow_r <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Storage is not reset. On a full-FIFO read+write, rd_ptr == wr_ptr and the
  // read above sees the old entry because both updates are non-blocking.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.pl_in;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.count      = count_r;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_pl_word_buffer.sv
module tb_pl_word_buffer;

  localparam int W = 6;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pl_word_buffer_if #(.WIDTH(W), .AW(3)) bus ();

  pl_word_buffer #(.WIDTH(W), .DEPTH(D), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the FIFO contents as a plain queue, plus scoreboard of
  // words the consumer should see on dout_valid pulses.
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  bit           prev_v = 1'b0;
  bit           m_ovf  = 1'b0;
  logic [W-1:0] m_dout = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every dout_valid pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && bus.dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dout_valid", 1, 0);
      end else begin
        chk("dout_data", int'(bus.dout), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; inputs applied at posedge+1, status checked after.
  task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit c);
    bit wr_req, rd_acc, wr_acc;
    logic [W-1:0] got;
    bus.valid_in = v;
    bus.pl_in    = d;
    bus.rd_en    = r;
    bus.clr_ovf  = c;
    wr_req = v && !prev_v;
    prev_v = v;
    rd_acc = r && (mq.size() > 0);
    wr_acc = wr_req && ((mq.size() < D) || rd_acc);
    if (rd_acc) begin
      got = mq.pop_front();
      exp_q.push_back(got);
      m_dout = got;
    end
    if (wr_acc) mq.push_back(d);
    if (wr_req && !wr_acc) m_ovf = 1'b1;
    else if (c)            m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("count",      int'(bus.count),      mq.size());
    chk("empty",      int'(bus.empty),      int'(mq.size() == 0));
    chk("full",       int'(bus.full),       int'(mq.size() == D));
    chk("overflow",   int'(bus.overflow),   int'(m_ovf));
    chk("dout_valid", int'(bus.dout_valid), int'(rd_acc));
    chk("dout_hold",  int'(bus.dout),       int'(m_dout));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    idle();
  endtask

  task automatic rd();
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic do_reset(input bit hold_v, input logic [W-1:0] d);
    bus.valid_in = hold_v;
    bus.pl_in    = d;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_count",      int'(bus.count),      0);
    chk("rst_empty",      int'(bus.empty),      1);
    chk("rst_full",       int'(bus.full),       0);
    chk("rst_dout",       int'(bus.dout),       0);
    chk("rst_dout_valid", int'(bus.dout_valid), 0);
    chk("rst_overflow",   int'(bus.overflow),   0);
    mq.delete();
    exp_q.delete();
    prev_v = 1'b0;
    m_ovf  = 1'b0;
    m_dout = '0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.pl_in    = '0;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, '0);

    // Held valid_in produces exactly one write.
    repeat (3) step(1'b1, 6'h2A, 1'b0, 1'b0);
    idle();
    rd();
    idle();

    // Fill, overflow on the ninth, drain in order.
    for (int i = 1; i <= 8; i++) wr(W'(i));
    wr(6'h09);
    for (int i = 0; i < 8; i++) rd();
    idle();

    // Full with simultaneous write and read.
    for (int i = 0; i < 8; i++) wr(W'(6'h20 + i));
    step(1'b1, 6'h15, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 8; i++) rd();
    idle();

    // Empty with simultaneous write and read: no fall-through.
    step(1'b1, 6'h33, 1'b1, 1'b0);
    idle();
    rd();
    idle();

    // Pointer wrap.
    for (int i = 0; i < 6; i++) wr(W'(i + 1));
    for (int i = 0; i < 6; i++) rd();
    for (int i = 0; i < 6; i++) wr(W'(6'h10 + i));
    for (int i = 0; i < 6; i++) rd();
    idle();

    // Overflow set, set-wins-over-clear, then clear.
    for (int i = 0; i < 9; i++) wr(W'(6'h30 + i));
    step(1'b1, 6'h3F, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle();

    // Reset mid-burst with valid_in high at release: that word is kept.
    do_reset(1'b0, '0);
    for (int i = 0; i < 5; i++) wr(W'(6'h05 + i));
    do_reset(1'b1, 6'h27);
    step(1'b1, 6'h27, 1'b0, 1'b0);
    idle();
    rd();
    idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1'($urandom_range(0, 1)), W'($urandom));
      end
      step(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0 ^ 1'($urandom_range(0, 1)),
           W'($urandom),
           1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 19) == 0));
    end

    // Drain and confirm nothing is left outstanding.
    for (int i = 0; i < D + 2; i++) rd();
    idle();
    idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
